seq_detector_param: RTL
=======================

// Module: seq_detector_param
// PURPOSE
//  Parametrised serial bit-pattern detector; generalises the fixed "111" Mealy FSM.
//  - Pattern (1..MAX_LEN bits) is runtime-loadable.
//  - Overlap and non-overlap modes; Mealy or Moore output timing.
//  - Saturating match counter.
//  - Sits on a 1-bit serial stream (A) qualified by en; feeds protocol/framing logic.
// PARAMETERS
//  MAX_LEN       8        max pattern length in bits (>=2)
//  RESET_LEN     3        pattern length after reset (1..MAX_LEN)
//  RESET_PATTERN 8'b111   pattern after reset, right-aligned in MAX_LEN bits
//  OVERLAP       1        1: matches may share bits; 0: history cleared after each match
//  MOORE         0        0: Y combinational in match cycle; 1: Y registered, 1 cycle later
//  CNT_W         8        width of match_count
// PORTS
//  clk         in   1                    rising-edge clock
//  reset       in   1                    synchronous, active-high reset
//  en          in   1                    A valid this cycle; A ignored when low
//  A           in   1                    serial input bit
//  pat_load    in   1                    load pat_in/len_in this cycle
//  pat_in      in   MAX_LEN              new pattern, right-aligned
//  len_in      in   $clog2(MAX_LEN+1)    new pattern length
//  Y           out  1                    match pulse
//  match_count out  CNT_W                saturating count of matches
//  cfg_err     out  1                    1-cycle pulse: load rejected
// BEHAVIOUR
//  - Reset (priority over all): pat=RESET_PATTERN, len=RESET_LEN, hist=0, fill=0,
//    match_count=0, cfg_err=0, Y=0. Mealy Y is gated to 0 while reset is high.
//  - Bit order: pat[len-1] is the first-received bit; pat[0] is the most recent bit.
//  - State: hist[MAX_LEN-1:0] shift history; fill = 0..MAX_LEN valid bits held.
//  - match_now = en & !pat_load & (fill >= len-1)
//    & ({hist,A}[len-1:0] == pat[len-1:0]).
//  - On en & !pat_load:
//    - hist <= {hist[MAX_LEN-2:0],A}.
//    - fill <= min(fill+1, MAX_LEN); if match_now & !OVERLAP, fill <= 0.
//  - en low: hist and fill hold; no match possible.
//  - Y: MOORE=0 -> Y = match_now (same cycle).
//    MOORE=1 -> Y <= match_now, exactly one cycle wide, one cycle after the match bit.
//  - match_count increments on match_now; saturates at 2^CNT_W-1 (no wrap).
//  - pat_load (priority over en): A is not sampled; match_now=0; fill <= 0.
//    - len_in in 1..MAX_LEN: pat <= pat_in, len <= len_in.
//    - Otherwise: pat and len unchanged; cfg_err=1 next cycle for one cycle.
//    - Either way the history is discarded.
//  - Moore Y for a match in cycle t is still emitted in t+1 even if t+1 is a load or en=0.
//  - len=1: every qualified bit equal to pat[0] matches, in both overlap modes.
//  - match_count is not cleared by pat_load; only reset clears it.
// STRUCTURE
//  - seq_det_pkg: MAX_LEN-derived width functions (len width); mode enum
//    {MEALY, MOORE}; default pattern constants.
//  - Sub-module sat_counter #(CNT_W): inc, clear(sync) -> count; saturating.
//  - Top holds config regs, hist/fill, compare, and Y timing.
// TESTING
//  1 Reset defaults ("111", OVERLAP=1, MEALY), en=1, A = 0,0,1,1,1,0,1,1,1,1,0
//    -> Y high on bits 4,8,9 (same cycle); match_count=3.
//  2 Same stream, OVERLAP=0 -> Y on bits 4,8 only; match_count=2.
//  3 Same stream, MOORE=1 -> Y high one cycle after bits 4,8,9; each pulse 1 cycle wide.
//  4 Load pat_in=4'b1011, len_in=4; stream 1,0,1,1,0,1,1
//    -> OVERLAP=1: Y on bits 3,6; OVERLAP=0: Y on bit 3 only.
//  5 Load len_in=0 or len_in=MAX_LEN+1 -> cfg_err pulse one cycle; "111" still detected;
//    en=0 gaps inside 1,1,1 still match on the third qualified 1.
//  6 CNT_W=2, six matches -> match_count sticks at 3; reset mid-stream after 1,1
//    -> a following single 1 does not match; count=0.

Source files
------------

// File: rtl/seq_det_pkg.sv
// =============================================================================
// seq_det_pkg : shared types, defaults and width helpers for the detector (rev 1.0)
// =============================================================================
`default_nettype none

package seq_det_pkg;

   typedef enum logic {
      MODE_MEALY = 1'b0,
      MODE_MOORE = 1'b1
   } out_mode_e;

   localparam int         DEFAULT_MAX_LEN = 8;
   localparam int         DEFAULT_LEN     = 3;
   localparam logic [7:0] DEFAULT_PATTERN = 8'b0000_0111;

   // Width needed to hold a length value in 0..max_len inclusive.
   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_detector_param_sat_counter.sv
// =============================================================================
// sat_counter : synchronous-clear counter that sticks at all-ones (rev 1.0)
// =============================================================================
`default_nettype none

module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != {CNT_W{1'b1}})) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

`default_nettype wire

// File: rtl/seq_detector_param.sv
// =============================================================================
// seq_detector_param : runtime-loadable serial pattern detector (rev 1.0)
// =============================================================================
`default_nettype none

module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int                       MAX_LEN       = DEFAULT_MAX_LEN,
   parameter int                       RESET_LEN     = DEFAULT_LEN,
   parameter logic [MAX_LEN-1:0]       RESET_PATTERN = MAX_LEN'(DEFAULT_PATTERN),
   parameter int                       OVERLAP       = 1,
   parameter int                       MOORE         = 0,
   parameter int                       CNT_W         = 8
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           en,
   input  logic                           A,
   input  logic                           pat_load,
   input  logic [MAX_LEN-1:0]             pat_in,
   input  logic [len_width(MAX_LEN)-1:0]  len_in,
   output logic                           Y,
   output logic [CNT_W-1:0]               match_count,
   output logic                           cfg_err
);

   localparam int        LEN_W = len_width(MAX_LEN);
   localparam out_mode_e MODE  = (MOORE != 0) ? MODE_MOORE : MODE_MEALY;

   logic [MAX_LEN-1:0] pat;
   logic [MAX_LEN-1:0] hist;
   logic [LEN_W-1:0]   len;
   logic [LEN_W-1:0]   fill;
   logic [MAX_LEN:0]   window;
   logic [MAX_LEN:0]   mask;
   logic               fill_ok;
   logic               len_ok;
   logic               match_now;

   // Newest bit sits at index 0, so the low len bits line up with pat directly.
   assign window    = {hist, A};
   assign mask      = ~({(MAX_LEN + 1){1'b1}} << len);
   assign fill_ok   = ({1'b0, fill} + (LEN_W + 1)'(1)) >= {1'b0, len};
   assign len_ok    = (len_in != '0) && (len_in <= LEN_W'(MAX_LEN));
   assign match_now = en && !pat_load && fill_ok &&
                      ((window & mask) == ({1'b0, pat} & mask));

   always_ff @(posedge clk) begin
      if (reset) begin
         pat     <= RESET_PATTERN;
         len     <= LEN_W'(RESET_LEN);
         hist    <= '0;
         fill    <= '0;
         cfg_err <= 1'b0;
      end else begin
         cfg_err <= pat_load && !len_ok;
         if (pat_load) begin
            hist <= '0;
            fill <= '0;
            if (len_ok) begin
               pat <= pat_in;
               len <= len_in;
            end
         end else if (en) begin
            hist <= window[MAX_LEN-1:0];
            if (match_now && (OVERLAP == 0)) begin
               fill <= '0;
            end else if (fill != LEN_W'(MAX_LEN)) begin
               fill <= fill + LEN_W'(1);
            end
         end
      end
   end

   generate
      if (MODE == MODE_MOORE) begin : g_moore
         logic y_reg;
         always_ff @(posedge clk) begin
            if (reset) begin
               y_reg <= 1'b0;
            end else begin
               y_reg <= match_now;
            end
         end
         assign Y = y_reg;
      end else begin : g_mealy
         assign Y = match_now && !reset;
      end
   endgenerate

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk   (clk),
      .clear (reset),
      .inc   (match_now),
      .count (match_count)
   );

endmodule

`default_nettype wire
